// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader_if
// Purpose  : Bundles the start/status, FIFO read-side and downstream
//            valid/ready signals of fifo_burst_reader.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   start        1-cycle start pulse (sampled by the reader only in IDLE)
//   burst_len    bytes to drain, sampled with start
//   fifo_empty   FIFO empty flag, core domain
//   fifo_data    FIFO read data, valid the cycle after an accepted read
//   fifo_read_en FIFO read strobe
//   out_data     downstream data
//   out_valid    downstream valid
//   out_ready    downstream ready
//   out_last     final beat of the burst
//   busy         burst in progress
//   done         1-cycle pulse, burst completed
//   timeout      1-cycle pulse, burst aborted (FIFO stayed empty too long)
//   beat_count   data bytes delivered in the current/last burst
// Modports
//   master : the reader itself (drives the FIFO strobe and downstream side)
//   slave  : the environment (FIFO, core consumer, controller)
// ============================================================================
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
);

  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [LEN_WIDTH-1:0]  beat_count;

  modport master (
    input  start,
    input  burst_len,
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_read_en,
    output out_data,
    output out_valid,
    output out_last,
    output busy,
    output done,
    output timeout,
    output beat_count
  );

  modport slave (
    output start,
    output burst_len,
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_read_en,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  busy,
    input  done,
    input  timeout,
    input  beat_count
  );

endinterface : fifo_burst_reader_if
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Core-domain controller that drains a fixed-length burst from the
//            read side of a dual-clock FIFO and forwards each byte downstream
//            over a valid/ready handshake. Started by a single start pulse;
//            reports busy, done and timeout status.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH     width of FIFO data and out_data (>= 8 when the checksum
//                  beat is built in)
//   MAX_BURST      largest burst; a larger burst_len is clamped to this
//   LEN_WIDTH      width of burst_len / beat_count (must hold MAX_BURST)
//   TIMEOUT_CYCLES consecutive empty cycles in REQ before the burst aborts
// Ports
//   clk2   in  core clock, all logic on its rising edge
//   reset  in  synchronous, active-high reset
//   bus    fifo_burst_reader_if.master (start/burst_len, FIFO read side,
//          downstream valid/ready, busy/done/timeout/beat_count)
// Build option
//   BURST_CHECKSUM_EN : when defined, an extra beat carrying the mod-256 sum
//                       of the delivered bytes closes every completed burst
//                       and carries out_last; data beats have out_last = 0.
// ============================================================================
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 16,
  parameter int LEN_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk2,
  input  logic                reset,
  fifo_burst_reader_if.master bus
);

  // The empty-cycle counter only ever needs to hold TIMEOUT_CYCLES-1: the
  // cycle that would take it to TIMEOUT_CYCLES aborts the burst instead.
  localparam int TO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_WIDTH-1:0]  c_to_last   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] c_max_burst = LEN_WIDTH'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  w_len_nxt;
  logic [TO_WIDTH-1:0]   r_to_cnt;
  logic [TO_WIDTH-1:0]   w_to_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] w_out_data_nxt;
  logic                  r_out_valid;
  logic                  w_out_valid_nxt;
  logic                  r_out_last;
  logic                  w_out_last_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_timeout;
  logic                  w_timeout_nxt;
  logic [LEN_WIDTH-1:0]  r_beat_count;
  logic [LEN_WIDTH-1:0]  w_beat_count_nxt;
`ifdef BURST_CHECKSUM_EN
  logic [7:0]            r_sum;
  logic [7:0]            w_sum_nxt;
  logic                  r_csum_beat;   // the beat in SEND is the checksum
  logic                  w_csum_beat_nxt;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [LEN_WIDTH-1:0]  w_len_clamped;
  logic                  w_final_beat;
  logic                  w_read_en;

  assign w_len_clamped = (bus.burst_len > c_max_burst) ? c_max_burst : bus.burst_len;

  // beat_count still holds the count before the beat currently in CAPT/SEND.
  assign w_final_beat  = ((r_beat_count + LEN_WIDTH'(1)) == r_len);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_to_cnt_nxt     = r_to_cnt;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = r_out_valid;
    w_out_last_nxt   = r_out_last;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_beat_count_nxt = r_beat_count;
    w_read_en        = 1'b0;
`ifdef BURST_CHECKSUM_EN
    w_sum_nxt        = r_sum;
    w_csum_beat_nxt  = r_csum_beat;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_len_nxt        = w_len_clamped;
          w_beat_count_nxt = '0;
          w_to_cnt_nxt     = '0;
`ifdef BURST_CHECKSUM_EN
          w_sum_nxt        = '0;
          w_csum_beat_nxt  = 1'b0;
`endif
          if (w_len_clamped == '0) begin
`ifdef BURST_CHECKSUM_EN
            // An empty burst still closes with its (zero) checksum beat.
            w_state_nxt     = S_SEND;
            w_out_data_nxt  = '0;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = 1'b1;
            w_csum_beat_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
`else
            w_state_nxt     = S_FIN;
`endif
          end else begin
            w_state_nxt = S_REQ;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      S_REQ: begin
        // Read strobe follows the empty flag combinationally, so a read is
        // always accepted when issued and only one is ever in flight.
        w_read_en = !bus.fifo_empty;
        if (!bus.fifo_empty) begin
          w_state_nxt  = S_CAPT;
          w_to_cnt_nxt = '0;
        end else if (r_to_cnt == c_to_last) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_to_cnt_nxt  = '0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_WIDTH'(1);
        end
      end

      S_CAPT: begin
        w_out_data_nxt  = bus.fifo_data;
        w_out_valid_nxt = 1'b1;
`ifdef BURST_CHECKSUM_EN
        w_out_last_nxt  = 1'b0;
        w_sum_nxt       = r_sum + bus.fifo_data[7:0];
`else
        w_out_last_nxt  = w_final_beat;
`endif
        w_state_nxt     = S_SEND;
      end

      S_SEND: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
`ifdef BURST_CHECKSUM_EN
          if (r_csum_beat) begin
            w_state_nxt     = S_FIN;
            w_csum_beat_nxt = 1'b0;
          end else begin
            w_beat_count_nxt = r_beat_count + LEN_WIDTH'(1);
            if (w_final_beat) begin
              // Sum already includes this beat (accumulated in CAPT), so the
              // checksum beat follows back-to-back from SEND.
              w_out_data_nxt  = DATA_WIDTH'(r_sum);
              w_out_valid_nxt = 1'b1;
              w_out_last_nxt  = 1'b1;
              w_csum_beat_nxt = 1'b1;
            end else begin
              w_state_nxt = S_REQ;
            end
          end
`else
          w_beat_count_nxt = r_beat_count + LEN_WIDTH'(1);
          w_state_nxt      = w_final_beat ? S_FIN : S_REQ;
`endif
        end
      end

      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk2) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_to_cnt     <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_beat_count <= '0;
`ifdef BURST_CHECKSUM_EN
      r_sum        <= '0;
      r_csum_beat  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_timeout    <= w_timeout_nxt;
      r_beat_count <= w_beat_count_nxt;
`ifdef BURST_CHECKSUM_EN
      r_sum        <= w_sum_nxt;
      r_csum_beat  <= w_csum_beat_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fifo_read_en = w_read_en;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_last     = r_out_last;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.timeout      = r_timeout;
  assign bus.beat_count   = r_beat_count;

endmodule : fifo_burst_reader
`default_nettype wire
